// File: rtl/alu_ctrl_decode_stage.sv
// RV32I decode stage for the ALU: turns an instruction into ALU select, immediate,
// register indices and flags, held in an output register behind a valid/ready handshake.
module alu_ctrl_decode_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [4:0]       alu_sel,
    output logic [31:0]      imm,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             src2_imm,
    output logic             reg_we,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [4:0] SEL_ILL   = 5'd31;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd;
    logic [4:0]  w_alu;
    logic [31:0] w_imm;
    logic        w_s2;
    logic        w_ill;
    logic        w_in_ready;
    logic        w_accept;

    assign w_opc = in_instr[6:0];
    assign w_f3  = in_instr[14:12];
    assign w_f7  = in_instr[31:25];
    assign w_rd  = in_instr[11:7];

    // Start from the illegal encoding and only override on a recognised pattern.
    always_comb begin
        w_alu = SEL_ILL;
        w_imm = 32'd0;
        w_s2  = 1'b0;
        w_ill = 1'b1;
        case (w_opc)
            OPC_OPIMM: begin
                w_ill = 1'b0;
                w_s2  = 1'b1;
                w_imm = {{20{in_instr[31]}}, in_instr[31:20]};
                case (w_f3)
                    3'b000: w_alu = 5'd0;
                    3'b010: w_alu = 5'd1;
                    3'b011: w_alu = 5'd2;
                    3'b100: w_alu = 5'd3;
                    3'b110: w_alu = 5'd4;
                    3'b111: w_alu = 5'd5;
                    3'b001: begin
                        w_imm = {27'd0, in_instr[24:20]};
                        if (w_f7 == F7_ZERO) w_alu = 5'd6;
                        else                 w_ill = 1'b1;
                    end
                    default: begin
                        w_imm = {27'd0, in_instr[24:20]};
                        if      (w_f7 == F7_ZERO) w_alu = 5'd7;
                        else if (w_f7 == F7_ALT)  w_alu = 5'd8;
                        else                      w_ill = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                w_ill = 1'b0;
                if (w_f7 == F7_ZERO) begin
                    case (w_f3)
                        3'b000:  w_alu = 5'd9;
                        3'b001:  w_alu = 5'd11;
                        3'b010:  w_alu = 5'd12;
                        3'b011:  w_alu = 5'd13;
                        3'b100:  w_alu = 5'd14;
                        3'b101:  w_alu = 5'd15;
                        3'b110:  w_alu = 5'd17;
                        default: w_alu = 5'd18;
                    endcase
                end else if (w_f7 == F7_ALT && w_f3 == 3'b000) begin
                    w_alu = 5'd10;
                end else if (w_f7 == F7_ALT && w_f3 == 3'b101) begin
                    w_alu = 5'd16;
                end else begin
                    w_ill = 1'b1;
                end
            end
            OPC_LUI: begin
                w_ill = 1'b0;
                w_s2  = 1'b1;
                w_alu = 5'd19;
                w_imm = {in_instr[31:12], 12'd0};
            end
            default: ;
        endcase
        // An illegal result must not leak partial decode from the case above.
        if (w_ill) begin
            w_alu = SEL_ILL;
            w_imm = 32'd0;
            w_s2  = 1'b0;
        end
    end

    assign w_in_ready = !flush && (!out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign in_ready   = w_in_ready;

    logic             r_valid;
    logic [31:0]      r_pc;
    logic [4:0]       r_alu;
    logic [31:0]      r_imm;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic             r_s2;
    logic             r_we;
    logic             r_ill;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= 32'd0;
            r_alu   <= 5'd0;
            r_imm   <= 32'd0;
            r_rs1   <= 5'd0;
            r_rs2   <= 5'd0;
            r_rd    <= 5'd0;
            r_s2    <= 1'b0;
            r_we    <= 1'b0;
            r_ill   <= 1'b0;
            r_cnt   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_pc    <= in_pc;
            r_alu   <= w_alu;
            r_imm   <= w_imm;
            r_rs1   <= in_instr[19:15];
            r_rs2   <= in_instr[24:20];
            r_rd    <= w_rd;
            r_s2    <= w_s2;
            r_we    <= !w_ill && (w_rd != 5'd0);
            r_ill   <= w_ill;
            if (w_ill && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign out_pc      = r_pc;
    assign alu_sel     = r_alu;
    assign imm         = r_imm;
    assign rs1         = r_rs1;
    assign rs2         = r_rs2;
    assign rd          = r_rd;
    assign src2_imm    = r_s2;
    assign reg_we      = r_we;
    assign illegal     = r_ill;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// Scoreboard bench for alu_ctrl_decode_stage: directed instructions push hand-decoded
// bundles into a queue; a monitor pops and compares on every output handshake.
module tb_alu_ctrl_decode_stage;
    localparam int CNT_W = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  alu;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        s2;
        logic        we;
        logic        ill;
    } bnd_t;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [31:0]      in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [4:0]       alu_sel;
    logic [31:0]      imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             src2_imm;
    logic             reg_we;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    alu_ctrl_decode_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .alu_sel(alu_sel), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
        .src2_imm(src2_imm), .reg_we(reg_we), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bnd_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic bnd_t got_bundle();
        return '{out_pc, alu_sel, imm, rs1, rs2, rd, src2_imm, reg_we, illegal};
    endfunction

    function automatic bnd_t mk(input logic [4:0] alu, input logic [31:0] im,
                                input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                                input logic s2, input logic we, input logic ill);
        return '{32'd0, alu, im, a, b, d, s2, we, ill};
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Monitor: every output handshake consumes exactly one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got pc=%0h alu=%0d with empty scoreboard", out_pc, alu_sel);
            end else begin
                bnd_t e;
                bnd_t g;
                e = exp_q.pop_front();
                g = got_bundle();
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL bundle pc=%0h: got %h expected %h", e.pc, g, e);
                end else begin
                    $display("txn pc=%08h alu_sel=%0d imm=%08h rs1=%0d rs2=%0d rd=%0d s2=%0b we=%0b ill=%0b ok",
                             g.pc, g.alu, g.imm, g.rs1, g.rs2, g.rd, g.s2, g.we, g.ill);
                end
            end
        end
    end

    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input bnd_t e);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout pc=%0h: got in_ready=0 required 1", pc);
        end else begin
            e.pc = pc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_queue_empty", 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bnd_t ea;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 32'd0;
        out_ready = 1'b0;
        #2;
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_bundle", 128'(got_bundle()), 128'd0);
        chk("reset_cnt", 128'(illegal_cnt), 128'd0);
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        send(32'hFFF08293, 32'h100, mk(5'd0,  32'hFFFFFFFF, 5'd1, 5'd31, 5'd5, 1'b1, 1'b1, 1'b0));
        send(32'h402081B3, 32'h104, mk(5'd10, 32'h0,        5'd1, 5'd2,  5'd3, 1'b0, 1'b1, 1'b0));
        send(32'h4020D1B3, 32'h108, mk(5'd16, 32'h0,        5'd1, 5'd2,  5'd3, 1'b0, 1'b1, 1'b0));
        send(32'h40325213, 32'h10C, mk(5'd8,  32'h3,        5'd4, 5'd3,  5'd4, 1'b1, 1'b1, 1'b0));
        chk("cnt_before_illegal", 128'(illegal_cnt), 128'd0);
        send(32'hFE325213, 32'h110, mk(5'd31, 32'h0,        5'd4, 5'd3,  5'd4, 1'b0, 1'b0, 1'b1));
        chk("cnt_after_illegal", 128'(illegal_cnt), 128'd1);
        send(32'h123453B7, 32'h114, mk(5'd19, 32'h12345000, 5'd8, 5'd3,  5'd7, 1'b1, 1'b1, 1'b0));
        send(32'h12345037, 32'h118, mk(5'd19, 32'h12345000, 5'd8, 5'd3,  5'd0, 1'b1, 1'b0, 1'b0));
        send(32'h003100B3, 32'h11C, mk(5'd9,  32'h0,        5'd2, 5'd3,  5'd1, 1'b0, 1'b1, 1'b0));
        send(32'h7FF0F313, 32'h120, mk(5'd5,  32'h7FF,      5'd1, 5'd31, 5'd6, 1'b1, 1'b1, 1'b0));
        send(32'h80002093, 32'h124, mk(5'd1,  32'hFFFFF800, 5'd0, 5'd0,  5'd1, 1'b1, 1'b1, 1'b0));
        send(32'h402091B3, 32'h128, mk(5'd31, 32'h0,        5'd1, 5'd2,  5'd3, 1'b0, 1'b0, 1'b1));
        send(32'h00000000, 32'h12C, mk(5'd31, 32'h0,        5'd0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b1));
        drain();
        chk("cnt_three_illegal", 128'(illegal_cnt), 128'd3);

        // Backpressure: held bundle must stay put while the next instruction waits.
        out_ready = 1'b0;
        ea = mk(5'd9, 32'h0, 5'd2, 5'd3, 5'd1, 1'b0, 1'b1, 1'b0);
        send(32'h003100B3, 32'h200, ea);
        ea.pc    = 32'h200;
        in_valid = 1'b1;
        in_instr = 32'h40325213;
        in_pc    = 32'h204;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_bundle_stable", 128'(got_bundle()), 128'(ea));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h40325213, 32'h204, mk(5'd8, 32'h3, 5'd4, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0));
        drain();

        // Flush with a held bundle and an incoming illegal instruction.
        out_ready = 1'b0;
        send(32'h402081B3, 32'h300, mk(5'd10, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0));
        in_valid = 1'b1;
        in_instr = 32'h00000000;
        in_pc    = 32'h304;
        flush    = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 128'(out_valid), 128'd0);
        chk("flush_cnt_unchanged", 128'(illegal_cnt), 128'd3);
        void'(exp_q.pop_front());
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_nothing_loaded", 128'(out_valid), 128'd0);
        @(posedge clk);
        #1;

        // Counter saturation at all-ones.
        for (int i = 0; i < 4; i++)
            send(32'h0000007F, 32'h400 + 32'(i * 4), mk(5'd31, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1));
        chk("cnt_reach_max", 128'(illegal_cnt), 128'd7);
        for (int i = 0; i < 2; i++)
            send(32'h0000007F, 32'h420 + 32'(i * 4), mk(5'd31, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1));
        chk("cnt_saturated", 128'(illegal_cnt), 128'd7);
        drain();

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        send(32'h123453B7, 32'h500, mk(5'd19, 32'h12345000, 5'd8, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 128'(out_valid), 128'd0);
        chk("async_rst_bundle", 128'(got_bundle()), 128'd0);
        chk("async_rst_cnt", 128'(illegal_cnt), 128'd0);
        void'(exp_q.pop_front());
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'hFFF08293, 32'h600, mk(5'd0, 32'hFFFFFFFF, 5'd1, 5'd31, 5'd5, 1'b1, 1'b1, 1'b0));
        drain();
        chk("final_cnt", 128'(illegal_cnt), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
